rf_ldst_engine: RTL and testbench

RF_LDST_ENGINE -- requirements
Module: rf_ldst_engine

---
 rtl/rf_ldst_engine.sv | 124 ++++++++++++
 tb/tb_rf_ldst_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_ldst_engine.sv
// Moves line_num register-file lines to or from SDRAM over an Avalon-MM master,
// one line per bus transaction with at most one transaction outstanding.
module rf_ldst_engine #(
    parameter int RF_ADDR_W = 10,
    parameter int DATA_W    = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 store_start,
    input  logic [RF_ADDR_W-1:0] rf_addr,
    input  logic [31:0]          sdram_addr,
    input  logic [7:0]           line_num,
    output logic                 busy,
    output logic                 done,
    output logic                 rf_rd_en,
    output logic [RF_ADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0]    rf_rd_data,
    output logic                 rf_wr_en,
    output logic [RF_ADDR_W-1:0] rf_wr_addr,
    output logic [DATA_W-1:0]    rf_wr_data,
    output logic [31:0]          avm_address,
    output logic                 avm_read,
    output logic                 avm_write,
    output logic [DATA_W-1:0]    avm_writedata,
    input  logic [DATA_W-1:0]    avm_readdata,
    input  logic                 avm_readdatavalid,
    input  logic                 avm_waitrequest
);

    localparam logic [31:0] STRIDE = 32'(DATA_W / 8);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_RD,
        ST_WR,
        FIN
    } state_t;

    state_t                 state_reg;
    logic [RF_ADDR_W-1:0]   rf_addr_reg;
    logic [31:0]            sdram_addr_reg;
    logic [7:0]             remain_reg;
    logic [DATA_W-1:0]      wdata_reg;
    logic                   wr_first_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            rf_addr_reg    <= '0;
            sdram_addr_reg <= '0;
            remain_reg     <= '0;
            wdata_reg      <= '0;
            wr_first_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load_start || store_start) begin
                        rf_addr_reg    <= rf_addr;
                        sdram_addr_reg <= sdram_addr;
                        remain_reg     <= line_num;
                        if (line_num == 8'd0)
                            state_reg <= FIN;
                        else if (load_start)
                            state_reg <= LD_REQ;
                        else
                            state_reg <= ST_RD;
                    end
                end
                LD_REQ: begin
                    if (!avm_waitrequest)
                        state_reg <= LD_WAIT;
                end
                LD_WAIT: begin
                    if (avm_readdatavalid) begin
                        rf_addr_reg    <= rf_addr_reg + RF_ADDR_W'(1);
                        sdram_addr_reg <= sdram_addr_reg + STRIDE;
                        remain_reg     <= remain_reg - 8'd1;
                        state_reg      <= (remain_reg == 8'd1) ? FIN : LD_REQ;
                    end
                end
                ST_RD: begin
                    state_reg    <= ST_WR;
                    wr_first_reg <= 1'b1;
                end
                ST_WR: begin
                    // RF data is only valid in the first ST_WR cycle; hold it for stalls
                    if (wr_first_reg) begin
                        wdata_reg    <= rf_rd_data;
                        wr_first_reg <= 1'b0;
                    end
                    if (!avm_waitrequest) begin
                        rf_addr_reg    <= rf_addr_reg + RF_ADDR_W'(1);
                        sdram_addr_reg <= sdram_addr_reg + STRIDE;
                        remain_reg     <= remain_reg - 8'd1;
                        state_reg      <= (remain_reg == 8'd1) ? FIN : ST_RD;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == FIN);
    assign avm_read      = (state_reg == LD_REQ);
    assign avm_write     = (state_reg == ST_WR);
    assign avm_address   = sdram_addr_reg;
    assign avm_writedata = (avm_write && wr_first_reg) ? rf_rd_data : wdata_reg;
    assign rf_rd_en      = (state_reg == ST_RD);
    assign rf_rd_addr    = rf_addr_reg;
    // Read data flows straight into the RF in the cycle it arrives
    assign rf_wr_en      = (state_reg == LD_WAIT) && avm_readdatavalid;
    assign rf_wr_addr    = rf_addr_reg;
    assign rf_wr_data    = rf_wr_en ? avm_readdata : '0;

endmodule

// File: tb/tb_rf_ldst_engine.sv
// Directed bench for rf_ldst_engine: SDRAM and RF models, expected-transaction
// queues filled by the stimulus and drained by an independent monitor.
module tb_rf_ldst_engine;

    localparam int AW = 10;
    localparam int DW = 128;

    logic          clk;
    logic          rst;
    logic          load_start, store_start;
    logic [AW-1:0] rf_addr;
    logic [31:0]   sdram_addr;
    logic [7:0]    line_num;
    logic          busy, done;
    logic          rf_rd_en;
    logic [AW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_rd_data;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic [31:0]   avm_address;
    logic          avm_read, avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;
    logic          avm_waitrequest;

    rf_ldst_engine #(.RF_ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .store_start(store_start),
        .rf_addr(rf_addr), .sdram_addr(sdram_addr), .line_num(line_num),
        .busy(busy), .done(done),
        .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   addr;
        logic [DW-1:0] data;
    } xact_t;
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    xact_t exp_rd[$];
    xact_t exp_wr[$];
    xact_t exp_rfw[$];
    xact_t exp_rfr[$];
    rsp_t  rsp_q[$];

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int stall_cfg = 0;
    int stall_cnt = 0;
    int rd_lat    = 2;

    logic [DW-1:0] rf_mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] sd_pat(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h0000_1111, 32'hC0DE_0000 | a};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Register-file read port: one cycle of latency
    always @(posedge clk) begin
        if (rf_rd_en) rf_rd_data <= rf_mem[rf_rd_addr];
    end

    // SDRAM slave model, driven on the falling edge
    always @(negedge clk) begin
        rsp_t r;
        cyc++;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = r.data;
        end
        if ((avm_read || avm_write) && stall_cnt < stall_cfg) begin
            avm_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            avm_waitrequest = 1'b0;
            stall_cnt = 0;
            if (avm_read && !rst)
                rsp_q.push_back('{due: cyc + rd_lat, data: sd_pat(avm_address)});
        end
    end

    // Monitor: compares every observed transaction against the expected queues
    logic          hold_v = 1'b0;
    logic [31:0]   hold_addr;
    logic [DW-1:0] hold_data;
    always @(negedge clk) begin
        xact_t e;
        #1;
        chk("exclusive_strobes", DW'({avm_read & avm_write, rf_rd_en & rf_wr_en}), '0);
        if (avm_read && !avm_waitrequest) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", DW'(avm_address), '1);
            else begin
                e = exp_rd.pop_front();
                chk("rd_addr", DW'(avm_address), DW'(e.addr));
            end
        end
        if (avm_write && hold_v) begin
            chk("wr_hold_addr", DW'(avm_address), DW'(hold_addr));
            chk("wr_hold_data", avm_writedata, hold_data);
        end
        hold_v    = avm_write && avm_waitrequest;
        hold_addr = avm_address;
        hold_data = avm_writedata;
        if (avm_write && !avm_waitrequest) begin
            if (exp_wr.size() == 0) chk("wr_unexpected", DW'(avm_address), '1);
            else begin
                e = exp_wr.pop_front();
                chk("wr_addr", DW'(avm_address), DW'(e.addr));
                chk("wr_data", avm_writedata, e.data);
            end
        end
        if (rf_wr_en) begin
            if (exp_rfw.size() == 0) chk("rfw_unexpected", DW'(rf_wr_addr), '1);
            else begin
                e = exp_rfw.pop_front();
                chk("rfw_addr", DW'(rf_wr_addr), DW'(e.addr));
                chk("rfw_data", rf_wr_data, e.data);
            end
        end
        if (rf_rd_en) begin
            if (exp_rfr.size() == 0) chk("rfr_unexpected", DW'(rf_rd_addr), '1);
            else begin
                e = exp_rfr.pop_front();
                chk("rfr_addr", DW'(rf_rd_addr), DW'(e.addr));
            end
        end
        if (done) done_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic ld, input logic st, input logic [AW-1:0] ra,
                             input logic [31:0] sa, input logic [7:0] n);
        load_start  = ld;
        store_start = st;
        rf_addr     = ra;
        sdram_addr  = sa;
        line_num    = n;
        step();
        load_start  = 1'b0;
        store_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (done) break;
            step();
        end
        chk({name, "_done_seen"}, DW'(i < budget), DW'(1));
        step();
        chk({name, "_idle_after"}, DW'(busy), DW'(0));
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_strobes"}, DW'({busy, done, rf_rd_en, rf_wr_en, avm_read, avm_write}), '0);
        chk({name, "_addrs"}, DW'({rf_rd_addr, rf_wr_addr, avm_address}), '0);
        chk({name, "_wdata"}, avm_writedata, '0);
    endtask

    task automatic chk_queues(input string name);
        chk({name, "_queues_empty"},
            DW'(exp_rd.size() + exp_wr.size() + exp_rfw.size() + exp_rfr.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int seen;
        logic [DW-1:0] d_hi, d_lo;
        rst = 1'b1; load_start = 1'b0; store_start = 1'b0;
        rf_addr = '0; sdram_addr = '0; line_num = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        rf_rd_data = '0;
        step(); step();
        chk_idle_outputs("reset_during");
        rst = 1'b0;
        step();
        chk_idle_outputs("reset_after");

        // Three-line load, no stalls, read latency 2
        stall_cfg = 0; rd_lat = 2; base = done_cnt;
        for (int i = 0; i < 3; i++) begin
            exp_rd.push_back('{addr: 32'h1000 + 32'(16 * i), data: '0});
            exp_rfw.push_back('{addr: 32'h010 + 32'(i), data: sd_pat(32'h1000 + 32'(16 * i))});
        end
        start_cmd(1'b1, 1'b0, 10'h010, 32'h1000, 8'd3);
        chk("load3_busy", DW'(busy), DW'(1));
        wait_done("load3", 40);
        chk("load3_done_count", DW'(done_cnt - base), DW'(1));
        chk_queues("load3");

        // Two-line store across both address wraps, 3 stall cycles per beat
        d_hi = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F0F_3FF0;
        d_lo = 128'h1357_9BDF_2468_ACE0_FEDC_BA98_7654_0000;
        rf_mem[10'h3FF] = d_hi;
        rf_mem[10'h000] = d_lo;
        stall_cfg = 3; base = done_cnt;
        exp_rfr.push_back('{addr: 32'h3FF, data: '0});
        exp_rfr.push_back('{addr: 32'h000, data: '0});
        exp_wr.push_back('{addr: 32'hFFFF_FFF0, data: d_hi});
        exp_wr.push_back('{addr: 32'h0000_0000, data: d_lo});
        start_cmd(1'b0, 1'b1, 10'h3FF, 32'hFFFF_FFF0, 8'd2);
        wait_done("store2", 60);
        chk("store2_done_count", DW'(done_cnt - base), DW'(1));
        chk_queues("store2");

        // Zero-length load: done in the cycle right after the start cycle
        stall_cfg = 0; base = done_cnt;
        start_cmd(1'b1, 1'b0, 10'h123, 32'h8000, 8'd0);
        chk("zero_done_next", DW'({done, busy}), DW'(2'b11));
        step();
        chk("zero_done_once", DW'({done, busy}), DW'(2'b00));
        step();
        chk("zero_done_count", DW'(done_cnt - base), DW'(1));

        // Simultaneous starts: load wins; a store issued while busy is dropped
        rd_lat = 2; base = done_cnt;
        exp_rd.push_back('{addr: 32'h2000, data: '0});
        exp_rfw.push_back('{addr: 32'h020, data: sd_pat(32'h2000)});
        start_cmd(1'b1, 1'b1, 10'h020, 32'h2000, 8'd1);
        start_cmd(1'b0, 1'b1, 10'h0AA, 32'h9000, 8'd2);
        wait_done("prio", 30);
        for (int i = 0; i < 6; i++) step();
        chk("prio_still_idle", DW'(busy), DW'(0));
        chk("prio_done_count", DW'(done_cnt - base), DW'(1));
        chk_queues("prio");

        // Reset in LD_WAIT of a four-line load, then a clean load
        rd_lat = 4; base = done_cnt;
        exp_rd.push_back('{addr: 32'h4000, data: '0});
        start_cmd(1'b1, 1'b0, 10'h040, 32'h4000, 8'd4);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (avm_read && !avm_waitrequest) begin seen = 1; break; end
            step();
        end
        chk("rst_read_issued", DW'(seen), DW'(1));
        step();
        rst = 1'b1;
        step();
        chk_idle_outputs("rst_mid");
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (avm_readdatavalid) begin
                seen = 1;
                chk("late_rdv_no_write", DW'(rf_wr_en), DW'(0));
                break;
            end
            step();
        end
        chk("late_rdv_seen", DW'(seen), DW'(1));
        step();
        rd_lat = 2;
        for (int i = 0; i < 2; i++) begin
            exp_rd.push_back('{addr: 32'h5000 + 32'(16 * i), data: '0});
            exp_rfw.push_back('{addr: 32'h050 + 32'(i), data: sd_pat(32'h5000 + 32'(16 * i))});
        end
        start_cmd(1'b1, 1'b0, 10'h050, 32'h5000, 8'd2);
        wait_done("post_rst", 40);
        chk("post_rst_done_count", DW'(done_cnt - base), DW'(1));
        chk_queues("post_rst");

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
